tb_vp_status_responder: RTL and testbench

//  Virtual-peripheral responder on the core data bus (OBI-style req/gnt/rvalid).

---
 rtl/tb_vp_status_responder.sv | 177 +++++++++++++++++
 tb/tb_tb_vp_status_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_vp_status_responder.sv
// Virtual-peripheral status responder: decodes firmware writes to a 16-byte window into
// pass/fail/exit flags, buffers console characters and exposes a free-running cycle counter.
module tb_vp_status_responder #(
    parameter logic [31:0] PASS_MAGIC       = 32'd123456789,
    parameter logic [31:0] FAIL_MAGIC       = 32'd1,
    parameter int unsigned PRINT_FIFO_DEPTH = 8
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        print_valid_o,
    output logic [7:0]  print_char_o,
    input  logic        print_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int unsigned   AW      = $clog2(PRINT_FIFO_DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(PRINT_FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_EXIT   = 2'd1,
        REG_PRINT  = 2'd2,
        REG_CYCLES = 2'd3
    } reg_sel_e;

    reg_sel_e      reg_sel_s;
    logic          fifo_full_s, fifo_empty_s;
    logic          gnt_s, accept_s, push_s, pop_s;
    logic          unused_addr_s;

    logic [31:0]   status_q, status_d;
    logic          passed_q, passed_d;
    logic          failed_q, failed_d;
    logic          exit_valid_q, exit_valid_d;
    logic [31:0]   exit_value_q, exit_value_d;
    logic          rvalid_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   cycle_cnt_q;
    logic [7:0]    fifo_mem_q [PRINT_FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;

    assign reg_sel_s     = reg_sel_e'(data_addr_i[3:2]);
    assign unused_addr_s = ^{data_addr_i[31:4], data_addr_i[1:0]};
    assign fifo_full_s   = (count_q == DEPTH_C);
    assign fifo_empty_s  = (count_q == {CW{1'b0}});
    // A full FIFO stalls PRINT writes; a pop in the same cycle does not release the stall.
    assign gnt_s         = data_req_i && !(data_we_i && (reg_sel_s == REG_PRINT) && fifo_full_s);
    assign accept_s      = data_req_i && gnt_s;
    assign pop_s         = !fifo_empty_s && print_ready_i;

    // Register decode: next flag/shadow state and the response for an accepted transfer.
    always_comb begin
        status_d     = status_q;
        passed_d     = passed_q;
        failed_d     = failed_q;
        exit_valid_d = exit_valid_q;
        exit_value_d = exit_value_q;
        push_s       = 1'b0;
        rdata_d      = 32'h0000_0000;
        err_d        = 1'b0;
        if (accept_s) begin
            if (data_we_i) begin
                case (reg_sel_s)
                    REG_STATUS: begin
                        if (data_be_i == 4'hF) begin
                            status_d = data_wdata_i;
                            passed_d = passed_q | (data_wdata_i == PASS_MAGIC);
                            failed_d = failed_q | (data_wdata_i == FAIL_MAGIC);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    REG_EXIT: begin
                        if (data_be_i == 4'hF) begin
                            exit_valid_d = 1'b1;
                            exit_value_d = exit_valid_q ? exit_value_q : data_wdata_i;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    REG_PRINT: begin
                        if (data_be_i[0]) begin
                            push_s = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    REG_CYCLES: err_d = 1'b1;
                    default:    err_d = 1'b1;
                endcase
            end else begin
                case (reg_sel_s)
                    REG_STATUS: rdata_d = status_q;
                    REG_EXIT:   rdata_d = exit_value_q;
                    REG_PRINT:  rdata_d = {{(32-CW){1'b0}}, count_q};
                    REG_CYCLES: rdata_d = cycle_cnt_q;
                    default:    rdata_d = 32'h0000_0000;
                endcase
            end
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // FIFO occupancy update for push/pop combinations.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, flags, response and counter registers.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            status_q     <= 32'h0000_0000;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= 32'h0000_0000;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
            cycle_cnt_q  <= 32'h0000_0000;
            wptr_q       <= {AW{1'b0}};
            rptr_q       <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
        end else begin
            status_q     <= status_d;
            passed_q     <= passed_d;
            failed_q     <= failed_d;
            exit_valid_q <= exit_valid_d;
            exit_value_q <= exit_value_d;
            rvalid_q     <= accept_s;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cycle_cnt_q  <= cycle_cnt_q + 32'd1;
            wptr_q       <= push_s ? wptr_q + AW'(1) : wptr_q;
            rptr_q       <= pop_s ? rptr_q + AW'(1) : rptr_q;
            count_q      <= count_d;
        end
    end

    // Character storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge core_clk) begin
        if (push_s) begin
            fifo_mem_q[wptr_q] <= data_wdata_i[7:0];
        end
    end

    assign data_gnt_o     = gnt_s;
    assign data_rvalid_o  = rvalid_q;
    assign data_rdata_o   = rdata_q;
    assign data_err_o     = err_q;
    assign print_valid_o  = !fifo_empty_s;
    assign print_char_o   = fifo_empty_s ? 8'h00 : fifo_mem_q[rptr_q];
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;
endmodule

// File: tb/tb_tb_vp_status_responder.sv
// Scoreboard bench for tb_vp_status_responder: stimulus queues expected responses,
// a negedge monitor pops and compares them whenever rvalid is seen.
module tb_tb_vp_status_responder;
    localparam logic [31:0] A_STATUS = 32'h2000_0000;
    localparam logic [31:0] A_EXIT   = 32'h2000_0004;
    localparam logic [31:0] A_PRINT  = 32'h2000_0008;
    localparam logic [31:0] A_CYCLES = 32'h2000_000C;
    localparam logic [31:0] PASS_V   = 32'd123456789;

    logic        core_clk = 1'b0;
    logic        core_rst_n;
    logic        data_req_i, data_we_i, print_ready_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [3:0]  data_be_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o, print_valid_o;
    logic [31:0] data_rdata_o, exit_value_o;
    logic [7:0]  print_char_o;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cyc_seen[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          last_wait;

    tb_vp_status_responder dut (
        .core_clk      (core_clk),
        .core_rst_n    (core_rst_n),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .print_valid_o (print_valid_o),
        .print_char_o  (print_char_o),
        .print_ready_i (print_ready_i),
        .tests_passed_o(tests_passed_o),
        .tests_failed_o(tests_failed_o),
        .exit_valid_o  (exit_valid_o),
        .exit_value_o  (exit_value_o)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest queued expectation.
    always @(negedge core_clk) begin
        if (core_rst_n && data_rvalid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response", data_rdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_err", {31'd0, data_err_o}, {31'd0, mon_e.err});
                if (mon_e.chk_data) chk("rsp_rdata", data_rdata_o, mon_e.rdata);
                else cyc_seen.push_back(data_rdata_o);
            end
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input logic cd);
        exp_t e;
        int   n;
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wd;
        e.rdata = er;
        e.err = ee;
        e.chk_data = cd;
        exp_q.push_back(e);
        n = 0;
        @(negedge core_clk);
        while (!data_gnt_o && n < 50) begin
            n++;
            @(negedge core_clk);
        end
        last_wait = n;
        if (!data_gnt_o) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got gnt=0 for 50 cycles at addr %h expected grant", addr);
            void'(exp_q.pop_back());
            data_req_i = 1'b0;
        end else begin
            @(posedge core_clk);
            #1;
            data_req_i = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(posedge core_clk);
        end
        #1;
        chk("rsp_drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        core_rst_n    = 1'b0;
        data_req_i    = 1'b0;
        data_we_i     = 1'b0;
        data_addr_i   = 32'h0;
        data_be_i     = 4'h0;
        data_wdata_i  = 32'h0;
        print_ready_i = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        chk("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
        chk("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        chk("rst_rdata", data_rdata_o, 32'd0);
        chk("rst_err", {31'd0, data_err_o}, 32'd0);
        chk("rst_pvalid", {31'd0, print_valid_o}, 32'd0);
        chk("rst_pchar", {24'd0, print_char_o}, 32'd0);
        chk("rst_flags", {28'd0, tests_passed_o, tests_failed_o, exit_valid_o, 1'b0}, 32'd0);
        chk("rst_exitval", exit_value_o, 32'd0);
        core_rst_n = 1'b1;
        @(posedge core_clk);
        #1;

        // 1: pass magic
        bus(1'b1, A_STATUS, 4'hF, PASS_V, 32'd0, 1'b0, 1'b1);
        chk("t1_gnt_wait", last_wait, 32'd0);
        chk("t1_passed", {31'd0, tests_passed_o}, 32'd1);
        chk("t1_failed", {31'd0, tests_failed_o}, 32'd0);

        // 2: fail magic, repeat pass, neutral value, shadow read
        bus(1'b1, A_STATUS, 4'hF, 32'd1, 32'd0, 1'b0, 1'b1);
        chk("t2_failed", {31'd0, tests_failed_o}, 32'd1);
        bus(1'b1, A_STATUS, 4'hF, PASS_V, 32'd0, 1'b0, 1'b1);
        bus(1'b1, A_STATUS, 4'hF, 32'd5, 32'd0, 1'b0, 1'b1);
        chk("t2_flags", {30'd0, tests_passed_o, tests_failed_o}, 32'd3);
        bus(1'b0, A_STATUS, 4'h0, 32'd0, 32'd5, 1'b0, 1'b1);

        // 3: exit latched from first write only
        bus(1'b1, A_EXIT, 4'hF, 32'h2A, 32'd0, 1'b0, 1'b1);
        bus(1'b1, A_EXIT, 4'hF, 32'h7, 32'd0, 1'b0, 1'b1);
        chk("t3_exit_valid", {31'd0, exit_valid_o}, 32'd1);
        chk("t3_exit_value", exit_value_o, 32'h2A);
        bus(1'b0, A_EXIT, 4'hF, 32'd0, 32'h2A, 1'b0, 1'b1);
        wait_drain();

        // 4: fill FIFO, stall the ninth write, drain in order
        for (int i = 0; i < 8; i++) begin
            bus(1'b1, A_PRINT, (i % 2 == 0) ? 4'h1 : 4'hF, 32'h41 + i, 32'd0, 1'b0, 1'b1);
        end
        bus(1'b0, A_PRINT, 4'hF, 32'd0, 32'd8, 1'b0, 1'b1);
        wait_drain();
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = A_PRINT;
        data_be_i    = 4'hF;
        data_wdata_i = 32'h49;
        exp_q.push_back('{rdata: 32'd0, err: 1'b0, chk_data: 1'b1});
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            chk("t4_stall_gnt", {31'd0, data_gnt_o}, 32'd0);
        end
        @(posedge core_clk);
        #1;
        print_ready_i = 1'b1;
        @(negedge core_clk);
        chk("t4_gnt_during_pop", {31'd0, data_gnt_o}, 32'd0);
        chk("t4_head0", {23'd0, print_valid_o, print_char_o}, {23'd0, 1'b1, 8'h41});
        @(posedge core_clk);
        #1;
        print_ready_i = 1'b0;
        @(negedge core_clk);
        chk("t4_gnt_after_space", {31'd0, data_gnt_o}, 32'd1);
        @(posedge core_clk);
        #1;
        data_req_i = 1'b0;
        wait_drain();
        print_ready_i = 1'b1;
        for (int i = 1; i < 9; i++) begin
            @(negedge core_clk);
            chk("t4_drain", {23'd0, print_valid_o, print_char_o}, {23'd0, 1'b1, 8'h41 + 8'(i)});
            @(posedge core_clk);
        end
        #1;
        print_ready_i = 1'b0;
        chk("t4_empty", {31'd0, print_valid_o}, 32'd0);
        bus(1'b1, A_PRINT, 4'h2, 32'h5A, 32'd0, 1'b1, 1'b1);
        chk("t4_be0_nopush", {31'd0, print_valid_o}, 32'd0);
        wait_drain();

        // 5: cycle counter delta, wrap and write error
        cyc_seen.delete();
        bus(1'b0, A_CYCLES, 4'hF, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) bus(1'b0, A_STATUS, 4'hF, 32'd0, 32'd5, 1'b0, 1'b1);
        bus(1'b0, A_CYCLES, 4'hF, 32'd0, 32'd0, 1'b0, 1'b0);
        wait_drain();
        chk("t5_samples", cyc_seen.size(), 32'd2);
        if (cyc_seen.size() == 2) chk("t5_delta", cyc_seen[1] - cyc_seen[0], 32'd4);
        cyc_seen.delete();
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        @(posedge core_clk);
        #1;
        release dut.cycle_cnt_q;
        @(posedge core_clk);
        #1;
        bus(1'b0, A_CYCLES, 4'hF, 32'd0, 32'd0, 1'b0, 1'b0);
        wait_drain();
        chk("t5_wrap_samples", cyc_seen.size(), 32'd1);
        if (cyc_seen.size() == 1) chk("t5_wrap_small", {31'd0, cyc_seen[0] < 32'd16}, 32'd1);
        bus(1'b1, A_CYCLES, 4'hF, 32'd99, 32'd0, 1'b1, 1'b1);
        wait_drain();

        // 6: reset with a response pending, then partial-byte STATUS write
        bus(1'b1, A_PRINT, 4'hF, 32'h5A, 32'd0, 1'b0, 1'b1);
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = A_PRINT;
        data_be_i    = 4'hF;
        data_wdata_i = 32'h59;
        @(negedge core_clk);
        chk("t6_gnt", {31'd0, data_gnt_o}, 32'd1);
        @(posedge core_clk);
        #1;
        data_req_i = 1'b0;
        core_rst_n = 1'b0;
        #1;
        chk("t6_rvalid_dropped", {31'd0, data_rvalid_o}, 32'd0);
        chk("t6_fifo_empty", {31'd0, print_valid_o}, 32'd0);
        chk("t6_flags", {29'd0, tests_passed_o, tests_failed_o, exit_valid_o}, 32'd0);
        repeat (2) @(posedge core_clk);
        #1;
        core_rst_n = 1'b1;
        repeat (4) @(posedge core_clk);
        #1;
        bus(1'b1, A_STATUS, 4'h3, PASS_V, 32'd0, 1'b1, 1'b1);
        chk("t6_be_noflag", {31'd0, tests_passed_o}, 32'd0);
        bus(1'b0, A_STATUS, 4'hF, 32'd0, 32'd0, 1'b0, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
